// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - shares one floating_point_unit among NUM_REQ requesters
//
// Purpose:
//   Grants one requester at a time, sequences the FPU start/done/clear protocol,
//   returns the result tagged with the owning requester on one response channel,
//   and aborts a hung FPU operation with a watchdog.
//
// Configuration macro:
//   FPU_ARB_PRIORITY_EN  requester 0 wins whenever it is valid in IDLE and does not
//                        move the round-robin pointer; requesters 1..NUM_REQ-1
//                        rotate among themselves. Undefined: plain round-robin.
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   TIMEOUT   RUN cycles without fpu_done before the operation is aborted (1..65535)
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   req_valid / req_ready      per-requester request handshake (req_ready one-hot)
//   req_op / req_a / req_b     per-requester op (2b) and operands (32b), slice i
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_z              owning requester index and result
//   rsp_overflow/underflow     FPU status flags captured with the result
//   rsp_timeout                set when the result is the watchdog NaN
//   fpu_start/op/a/b, fpu_clr  drive the FPU (fpu_clr is the FPU's active-high clear)
//   fpu_z/overflow/underflow,
//   fpu_busy, fpu_done         returned from the FPU

module fpu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2:0]              rsp_id,
    output logic [31:0]             rsp_z,
    output logic                    rsp_overflow,
    output logic                    rsp_underflow,
    output logic                    rsp_timeout,
    output logic                    fpu_start,
    output logic [1:0]              fpu_op,
    output logic [31:0]             fpu_a,
    output logic [31:0]             fpu_b,
    output logic                    fpu_clr,
    input  logic [31:0]             fpu_z,
    input  logic                    fpu_overflow,
    input  logic                    fpu_underflow,
    input  logic                    fpu_busy,
    input  logic                    fpu_done
);

    localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP,
        S_CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [15:0] wd_q;
    logic [16:0] wd_next;
    logic        wd_hit;

    logic [1:0]  fpu_op_q;
    logic [31:0] fpu_a_q, fpu_b_q;
    logic [2:0]  rsp_id_q;
    logic [31:0] rsp_z_q;
    logic        rsp_overflow_q, rsp_underflow_q, rsp_timeout_q;

    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic [2:0]  cand;
    logic [7:0]  valid_ext;
    logic [1:0]  sel_op;
    logic [31:0] sel_a, sel_b;

    // (base + k) mod n for base < n and k < n, in requester-index width.
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int k, input int n);
        int s;
        s = int'({29'd0, base}) + k;
        if (s >= n) begin
            s = s - n;
        end
        return s[2:0];
    endfunction

    // Zero-extended so a 3-bit candidate index is always in range.
    assign valid_ext = 8'(req_valid);

    // ------------------------------------------------------------------
    // Arbitration: pick the winner and the pointer value it leaves behind
    // ------------------------------------------------------------------
`ifdef FPU_ARB_PRIORITY_EN
    logic [2:0] rr_base;

    // Requesters 1..NUM_REQ-1 form a ring of NUM_REQ-1 entries; ptr_q still
    // holds a real requester index, so shift it into ring coordinates. A
    // pointer of 0 (reset, or after requester NUM_REQ-1) starts at requester 1.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        rr_base     = (ptr_q == 3'd0) ? 3'd0 : (ptr_q - 3'd1);
        if (req_valid[0]) begin
            grant_valid = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = 3'd1 + wrap_add(rr_base, k, NUM_REQ - 1);
                if (!grant_valid && valid_ext[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        ptr_d = (grant_idx == 3'd0) ? ptr_q : wrap_add(grant_idx, 1, NUM_REQ);
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr_q, k, NUM_REQ);
            if (!grant_valid && valid_ext[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        ptr_d = wrap_add(grant_idx, 1, NUM_REQ);
    end
`endif

    // Operand mux for the winning requester.
    always_comb begin
        sel_op = 2'd0;
        sel_a  = 32'd0;
        sel_b  = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    // Watchdog fires on the cycle whose increment would reach TIMEOUT, so the
    // response appears TIMEOUT cycles after RUN is entered.
    assign wd_next = {1'b0, wd_q} + 17'd1;
    assign wd_hit  = (wd_next == 17'(TIMEOUT));

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    // Control outputs are gated with rst so every output except fpu_clr is
    // low while reset is held, even before the state register has returned
    // to IDLE.
    always_comb begin
        state_d   = state_q;
        fpu_start = 1'b0;
        rsp_valid = 1'b0;
        fpu_clr   = !rst;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = rst && grant_valid && (grant_idx == 3'(i));
                end
                if (grant_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                fpu_start = rst;
                if (fpu_done || wd_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = rst;
                if (rsp_ready) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                fpu_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= 3'd0;
            wd_q            <= 16'd0;
            fpu_op_q        <= 2'd0;
            fpu_a_q         <= 32'd0;
            fpu_b_q         <= 32'd0;
            rsp_id_q        <= 3'd0;
            rsp_z_q         <= 32'd0;
            rsp_overflow_q  <= 1'b0;
            rsp_underflow_q <= 1'b0;
            rsp_timeout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        fpu_op_q <= sel_op;
                        fpu_a_q  <= sel_a;
                        fpu_b_q  <= sel_b;
                        rsp_id_q <= grant_idx;
                        ptr_q    <= ptr_d;
                        wd_q     <= 16'd0;
                    end
                end
                S_RUN: begin
                    wd_q <= wd_next[15:0];
                    // A done in the same cycle as the watchdog wins.
                    if (fpu_done) begin
                        rsp_z_q         <= fpu_z;
                        rsp_overflow_q  <= fpu_overflow;
                        rsp_underflow_q <= fpu_underflow;
                        rsp_timeout_q   <= 1'b0;
                    end else if (wd_hit) begin
                        rsp_z_q         <= TIMEOUT_NAN;
                        rsp_overflow_q  <= 1'b0;
                        rsp_underflow_q <= 1'b0;
                        rsp_timeout_q   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fpu_op        = fpu_op_q;
    assign fpu_a         = fpu_a_q;
    assign fpu_b         = fpu_b_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_z         = rsp_z_q;
    assign rsp_overflow  = rsp_overflow_q;
    assign rsp_underflow = rsp_underflow_q;
    assign rsp_timeout   = rsp_timeout_q;

    // The FPU must report itself busy (or finished) for as long as it is started.
    a_run_busy: assert property (@(posedge clk) disable iff (!rst)
        (state_q == S_RUN) |-> (fpu_busy || fpu_done));

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - directed self-checking bench for fpu_share_arbiter

module tb_fpu_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 8;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2:0]            rsp_id;
    logic [31:0]           rsp_z;
    logic                  rsp_overflow;
    logic                  rsp_underflow;
    logic                  rsp_timeout;
    logic                  fpu_start;
    logic [1:0]            fpu_op;
    logic [31:0]           fpu_a;
    logic [31:0]           fpu_b;
    logic                  fpu_clr;
    logic [31:0]           fpu_z;
    logic                  fpu_overflow;
    logic                  fpu_underflow;
    logic                  fpu_busy;
    logic                  fpu_done;

    int checks = 0;
    int errors = 0;

    fpu_share_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
        .rsp_timeout(rsp_timeout),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_clr(fpu_clr),
        .fpu_z(fpu_z), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .fpu_busy(fpu_busy), .fpu_done(fpu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub FPU: done rises after 'lat' start cycles, holds until cleared;
    // 'hang' suppresses done entirely. Knows only the directed vectors.
    int          lat;
    logic        hang;
    logic [7:0]  dcnt;
    logic        done_q;
    logic [33:0] res_q;

    function automatic logic [33:0] stub_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        if (op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 2'b00};
        if (op == 2'd1 && a == 32'h40400000 && b == 32'h3F800000) return {32'h40000000, 2'b00};
        if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return {32'h40C00000, 2'b00};
        if (op == 2'd3 && a == 32'h40C00000 && b == 32'h40000000) return {32'h40400000, 2'b00};
        if (op == 2'd2 && a == 32'h7F000000 && b == 32'h7F000000) return {32'h7F800000, 2'b10};
        if (op == 2'd2 && a == 32'h00800000 && b == 32'h00800000) return {32'h00000000, 2'b01};
        return {32'hDEADBEEF, 2'b11};
    endfunction

    always @(posedge clk) begin
        if (fpu_clr) begin
            dcnt   <= 8'd0;
            done_q <= 1'b0;
            res_q  <= 34'd0;
        end else if (fpu_start && !done_q && !hang) begin
            dcnt <= dcnt + 8'd1;
            if (int'(dcnt) + 1 == lat) begin
                done_q <= 1'b1;
                res_q  <= stub_result(fpu_op, fpu_a, fpu_b);
            end
        end
    end

    assign fpu_done      = done_q;
    assign fpu_z         = res_q[33:2];
    assign fpu_overflow  = res_q[1];
    assign fpu_underflow = res_q[0];
    assign fpu_busy      = fpu_start & ~done_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Cycle 0: present a lone request and expect the grant; returns in cycle 1.
    task automatic issue(input int id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [NUM_REQ-1:0] oh;
        oh = NUM_REQ'(1 << id);
        req_op[2*id +: 2]  = op;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid = oh;
        #1;
        check_eq("grant", 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = '0;
        #1;
        check_eq("start", 32'(fpu_start), 32'd1);
        check_eq("fpu_a", fpu_a, a);
        check_eq("fpu_b", fpu_b, b);
        check_eq("fpu_op", 32'(fpu_op), 32'(op));
    endtask

    // Called in cycle 1; returns the cycle in which rsp_valid was first seen.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    // Response handshake this cycle (rsp_ready high): CLEAR, then IDLE.
    task automatic finish_rsp();
        @(negedge clk);
        #1;
        check_eq("clr_pulse", 32'(fpu_clr), 32'd1);
        check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check_eq("clr_end", 32'(fpu_clr), 32'd0);
    endtask

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic        hang;
        logic [31:0] z;
        logic        ov;
        logic        un;
        logic        to;
        int          cyc;
    } vec_t;

    vec_t vecs[8];
    int   cyc;
    int   exp_order[5];
    logic ok_stable, ok_ready, ok_start, ok_norsp;

    initial begin
        vecs[0] = '{1, 2'd0, 32'h3F800000, 32'h40000000, 2, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 4};
        vecs[1] = '{2, 2'd1, 32'h40400000, 32'h3F800000, 1, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 3};
        vecs[2] = '{3, 2'd2, 32'h7F000000, 32'h7F000000, 3, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, 5};
        vecs[3] = '{0, 2'd2, 32'h00800000, 32'h00800000, 2, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 4};
        vecs[4] = '{2, 2'd0, 32'h3F800000, 32'h40000000, 1, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 9};
        vecs[5] = '{1, 2'd2, 32'h40000000, 32'h40400000, 2, 1'b0, 32'h40C00000, 1'b0, 1'b0, 1'b0, 4};
        vecs[6] = '{3, 2'd3, 32'h40C00000, 32'h40000000, 7, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 9};
        vecs[7] = '{0, 2'd0, 32'h3F800000, 32'h40000000, 8, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 9};

        rst       = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        lat       = 2;
        hang      = 1'b0;

        // Reset state, with every requester asking.
        repeat (3) @(negedge clk);
        req_valid = '1;
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rvalid", 32'(rsp_valid), 32'd0);
        check_eq("rst_start", 32'(fpu_start), 32'd0);
        check_eq("rst_clr", 32'(fpu_clr), 32'd1);
        check_eq("rst_z", rsp_z, 32'd0);
        check_eq("rst_a", fpu_a, 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        #1;
        check_eq("clr_release", 32'(fpu_clr), 32'd0);

        // Single-requester vectors: results, flags, timeout and done/timeout tie.
        foreach (vecs[v]) begin
            lat  = vecs[v].lat;
            hang = vecs[v].hang;
            issue(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b);
            wait_rsp(cyc);
            check_eq($sformatf("v%0d_cycle", v), 32'(cyc), 32'(vecs[v].cyc));
            check_eq($sformatf("v%0d_id", v), 32'(rsp_id), 32'(vecs[v].id));
            check_eq($sformatf("v%0d_z", v), rsp_z, vecs[v].z);
            check_eq($sformatf("v%0d_ov", v), 32'(rsp_overflow), 32'(vecs[v].ov));
            check_eq($sformatf("v%0d_un", v), 32'(rsp_underflow), 32'(vecs[v].un));
            check_eq($sformatf("v%0d_to", v), 32'(rsp_timeout), 32'(vecs[v].to));
            finish_rsp();
        end
        hang = 1'b0;

        // Back-pressure: response held for 20 cycles while others request.
        lat = 2;
        issue(2, 2'd0, 32'h3F800000, 32'h40000000);
        rsp_ready = 1'b0;
        req_valid = 4'b1011;
        wait_rsp(cyc);
        check_eq("bp_cycle", 32'(cyc), 32'd4);
        ok_stable = 1'b1;
        ok_ready  = 1'b1;
        ok_start  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (!(rsp_valid && rsp_z == 32'h40400000 && rsp_id == 3'd2 && !rsp_timeout)) ok_stable = 1'b0;
            if (req_ready != '0) ok_ready = 1'b0;
            if (fpu_start) ok_start = 1'b0;
        end
        check_eq("bp_stable", 32'(ok_stable), 32'd1);
        check_eq("bp_noready", 32'(ok_ready), 32'd1);
        check_eq("bp_nostart", 32'(ok_start), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        finish_rsp();

        // Reset while RUN: operation abandoned, no response ever appears.
        lat = 3;
        issue(3, 2'd0, 32'h3F800000, 32'h40000000);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("mid_state", 32'(dut.state_q), 32'd0);
        check_eq("mid_start", 32'(fpu_start), 32'd0);
        check_eq("mid_rvalid", 32'(rsp_valid), 32'd0);
        check_eq("mid_clr", 32'(fpu_clr), 32'd1);
        check_eq("mid_a", fpu_a, 32'd0);
        check_eq("mid_z", rsp_z, 32'd0);
        rst = 1'b1;
        ok_norsp = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) ok_norsp = 1'b0;
        end
        check_eq("mid_norsp", 32'(ok_norsp), 32'd1);

        // All requesters held valid from reset.
        do_reset();
        lat = 1;
`ifdef FPU_ARB_PRIORITY_EN
        exp_order = '{0, 0, 1, 2, 3};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        req_op    = '0;
        req_a     = {NUM_REQ{32'h3F800000}};
        req_b     = {NUM_REQ{32'h40000000}};
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            #1;
            check_eq($sformatf("rr%0d_grant", g), 32'(req_ready), 32'(1 << exp_order[g]));
            @(negedge clk);
`ifdef FPU_ARB_PRIORITY_EN
            if (g == 1) req_valid[0] = 1'b0;
`endif
            #1;
            wait_rsp(cyc);
            check_eq($sformatf("rr%0d_cycle", g), 32'(cyc), 32'd3);
            check_eq($sformatf("rr%0d_id", g), 32'(rsp_id), 32'(exp_order[g]));
            check_eq($sformatf("rr%0d_z", g), rsp_z, 32'h40400000);
            @(negedge clk);
            if (g == 4) req_valid = '0;
            #1;
            check_eq($sformatf("rr%0d_clr", g), 32'(fpu_clr), 32'd1);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
